// File: rtl/hpdl1414_pkg.sv
// Shared types and constants for the HPDL-1414 display scanner.
// Holds the FSM encoding, the displayable character window and the chip geometry.
package hpdl1414_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [7:0]  CHAR_MIN        = 8'h20;
  localparam logic [7:0]  CHAR_MAX        = 8'h5F;
  localparam logic [7:0]  CHAR_BLANK      = 8'h20;
  localparam int unsigned NUM_CHIPS       = 4;
  localparam int unsigned DIGITS_PER_CHIP = 4;

  // The HPDL-1414 only has glyphs for 0x20..0x5F; anything else shows as a space.
  function automatic logic [6:0] map_char(input logic [7:0] c);
    if (c >= CHAR_MIN && c <= CHAR_MAX) return c[6:0];
    return CHAR_BLANK[6:0];
  endfunction

endpackage

// File: rtl/hpdl1414_scanner_if.sv
// Read port between the display buffer and the scanner, plus the caret blink phase.
interface hpdl1414_scanner_if;
  logic       read_enable;
  logic [3:0] read_address;
  logic [7:0] read_data;
  logic       caret_strobe;

  modport master (output read_enable, output read_address, output caret_strobe,
                  input  read_data);
  modport slave  (input  read_enable, input  read_address, input  caret_strobe,
                  output read_data);
endinterface

// File: rtl/hpdl1414_frame_timer.sv
// Free-running refresh tick plus the frame-counted caret blink phase.
module hpdl1414_frame_timer #(
  parameter int unsigned FRAME_CYCLES = 240000,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_frame_end,
  output logic o_frame_tick,
  output logic o_caret_strobe
);

  localparam int unsigned TW = $clog2(FRAME_CYCLES);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;

  assign o_frame_tick = (tick_cnt == TW'(FRAME_CYCLES - 1));

  // Blink advances on the same edge the scanner drops back to IDLE, so a frame never mixes phases.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tick_cnt       <= '0;
      blink_cnt      <= '0;
      o_caret_strobe <= 1'b1;
    end else begin
      tick_cnt <= o_frame_tick ? '0 : tick_cnt + 1'b1;
      if (i_frame_end) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt      <= '0;
          o_caret_strobe <= ~o_caret_strobe;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hpdl1414_scanner.sv
// Walks the 16-byte display buffer once per frame and writes each character
// into four HPDL-1414 chips using the chip's address/data/WR_n write cycle.
module hpdl1414_scanner
  import hpdl1414_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter int unsigned FRAME_CYCLES = 240000,
  parameter int unsigned BLINK_FRAMES = 25
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_refresh_req,
  hpdl1414_scanner_if.master    bus,
  output logic [1:0]            o_disp_addr,
  output logic [6:0]            o_disp_data,
  output logic [NUM_CHIPS-1:0]  o_disp_wr_n,
  output logic                  o_frame_done
);

  localparam int unsigned MAX_AB = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned MAXC   = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
  localparam int unsigned CW     = $clog2(MAXC + 1);

  state_t        state;
  logic [3:0]    idx;
  logic [CW-1:0] cyc;
  logic          pending;
  logic          frame_tick;
  logic          frame_end;
  logic          set_req;

  assign set_req   = frame_tick | i_refresh_req;
  assign frame_end = (state == HOLD) && (cyc == '0) && (idx == 4'd15);

  hpdl1414_frame_timer #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_frame_timer (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_frame_end    (frame_end),
    .o_frame_tick   (frame_tick),
    .o_caret_strobe (bus.caret_strobe)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state             <= IDLE;
      pending           <= 1'b1;
      idx               <= '0;
      cyc               <= '0;
      bus.read_enable   <= 1'b0;
      bus.read_address  <= '0;
      o_disp_addr       <= '0;
      o_disp_data       <= '0;
      o_disp_wr_n       <= '1;
      o_frame_done      <= 1'b0;
    end else begin
      bus.read_enable <= 1'b0;
      o_frame_done    <= 1'b0;
      if (set_req) pending <= 1'b1;

      case (state)
        IDLE: begin
          if (pending) begin
            // A request landing on the consume cycle keeps the flag set.
            if (!set_req) pending <= 1'b0;
            idx              <= '0;
            bus.read_address <= '0;
            bus.read_enable  <= 1'b1;
            state            <= READ;
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          o_disp_data <= map_char(bus.read_data);
          o_disp_addr <= 2'(DIGITS_PER_CHIP - 1) - idx[1:0];
          cyc         <= CW'(SETUP_CYCLES - 1);
          state       <= SETUP;
        end
        SETUP: begin
          if (cyc == '0) begin
            o_disp_wr_n <= ~(NUM_CHIPS'(1) << idx[3:2]);
            cyc         <= CW'(PULSE_CYCLES - 1);
            state       <= STROBE;
          end else begin
            cyc <= cyc - 1'b1;
          end
        end
        STROBE: begin
          if (cyc == '0) begin
            o_disp_wr_n <= '1;
            cyc         <= CW'(HOLD_CYCLES - 1);
            state       <= HOLD;
          end else begin
            cyc <= cyc - 1'b1;
          end
        end
        HOLD: begin
          if (cyc == '0) begin
            if (idx == 4'd15) begin
              o_frame_done <= 1'b1;
              state        <= IDLE;
            end else begin
              idx              <= idx + 4'd1;
              bus.read_address <= idx + 4'd1;
              bus.read_enable  <= 1'b1;
              state            <= READ;
            end
          end else begin
            cyc <= cyc - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hpdl1414_scanner.sv
// Bench for hpdl1414_scanner: buffer model, bus recorder and a per-frame
// reference of which chip/digit/character each write must carry.
module tb_hpdl1414_scanner;

  localparam int SETUP = 2;
  localparam int PULSE = 4;
  localparam int HOLD  = 2;

  typedef struct packed {
    logic [3:0] wr_n;
    logic [1:0] a;
    logic [6:0] d;
    logic       re;
    logic [3:0] ra;
    logic       fd;
  } samp_t;

  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic rst_b = 1'b1;
  logic req = 1'b0;

  logic [1:0] a_addr, b_addr;
  logic [6:0] a_data, b_data;
  logic [3:0] a_wr_n, b_wr_n;
  logic       a_fd, b_fd;

  hpdl1414_scanner_if bus_a ();
  hpdl1414_scanner_if bus_b ();

  hpdl1414_scanner #(
    .SETUP_CYCLES (SETUP), .PULSE_CYCLES (PULSE), .HOLD_CYCLES (HOLD),
    .FRAME_CYCLES (240000), .BLINK_FRAMES (25)
  ) dut (
    .i_clk (clk), .i_reset (i_reset), .i_refresh_req (req), .bus (bus_a),
    .o_disp_addr (a_addr), .o_disp_data (a_data), .o_disp_wr_n (a_wr_n),
    .o_frame_done (a_fd)
  );

  hpdl1414_scanner #(
    .SETUP_CYCLES (SETUP), .PULSE_CYCLES (PULSE), .HOLD_CYCLES (HOLD),
    .FRAME_CYCLES (400), .BLINK_FRAMES (2)
  ) dut_blink (
    .i_clk (clk), .i_reset (rst_b), .i_refresh_req (1'b0), .bus (bus_b),
    .o_disp_addr (b_addr), .o_disp_data (b_data), .o_disp_wr_n (b_wr_n),
    .o_frame_done (b_fd)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Buffer model: registered read port, garbage whenever not being read.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus_a.read_enable) bus_a.read_data <= mem[bus_a.read_address];
    else                   bus_a.read_data <= 8'($urandom);
  end
  assign bus_b.read_data = 8'h41;

  function automatic logic [6:0] ref_char(input int c);
    return (c >= 32 && c <= 95) ? 7'(c) : 7'd32;
  endfunction

  // Bus recorder for the main DUT, with the "no change while WR_n low" rule.
  samp_t q[$];
  samp_t cur, prev;
  bit    have_prev = 0;
  int    fd_total = 0;
  always @(posedge clk) begin
    #1;
    cur.wr_n = a_wr_n; cur.a = a_addr; cur.d = a_data;
    cur.re = bus_a.read_enable; cur.ra = bus_a.read_address; cur.fd = a_fd;
    if (have_prev && !i_reset && (prev.wr_n != 4'hF || cur.wr_n != 4'hF))
      check("stable_while_wr", 32'({cur.a, cur.d}), 32'({prev.a, prev.d}));
    prev = cur;
    have_prev = 1;
    q.push_back(cur);
    if (a_fd) fd_total++;
  end

  // Blink watcher on the fast-frame instance.
  int   b_frames = 0;
  int   b_toggles = 0;
  logic b_prev_caret = 1'b1;
  always @(posedge clk) begin
    #1;
    if (!rst_b) begin
      if (b_fd) b_frames++;
      if (bus_b.caret_strobe != b_prev_caret) begin
        b_toggles++;
        check("caret_only_at_frame_end", 32'(b_fd), 1);
        check("caret_every_2nd_frame", 32'(b_frames % 2), 0);
      end
      b_prev_caret = bus_b.caret_strobe;
    end
  end

  task automatic check_reset_outputs();
    check("rst_read_enable", 32'(bus_a.read_enable), 0);
    check("rst_read_address", 32'(bus_a.read_address), 0);
    check("rst_caret", 32'(bus_a.caret_strobe), 1);
    check("rst_disp_addr", 32'(a_addr), 0);
    check("rst_disp_data", 32'(a_data), 0);
    check("rst_wr_n", 32'(a_wr_n), 32'hF);
    check("rst_frame_done", 32'(a_fd), 0);
  endtask

  task automatic pulse_req();
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (a_fd) break;
    end
    check("frame_done_timeout", 32'(a_fd), 1);
  endtask

  // Reconstruct the frame from the recorded bus and compare with the buffer contents.
  task automatic analyze_frame();
    int reads[$];
    int starts[$];
    int dones[$];
    int s, r, len, bad;
    logic [3:0] ew;
    foreach (q[k]) begin
      if (q[k].re) begin
        reads.push_back(k);
        if (k + 1 < q.size()) check("read_single_cycle", 32'(q[k+1].re), 0);
      end
      if (q[k].wr_n != 4'hF && (k == 0 || q[k-1].wr_n == 4'hF)) starts.push_back(k);
      if (q[k].fd) dones.push_back(k);
    end
    check("n_reads", reads.size(), 16);
    check("n_writes", starts.size(), 16);
    check("n_frame_done", dones.size(), 1);
    for (int i = 0; i < 16 && i < starts.size() && i < reads.size(); i++) begin
      s = starts[i];
      r = reads[i];
      ew = ~(4'b0001 << (i / 4));
      check("read_addr", 32'(q[r].ra), i);
      check("read_to_wr", s - r, 2 + SETUP);
      check("wr_chip", 32'(q[s].wr_n), 32'(ew));
      check("digit", 32'(q[s].a), 3 - (i % 4));
      check("char", 32'(q[s].d), 32'(ref_char(int'(mem[i]))));
      len = 0;
      while (s + len < q.size() && q[s+len].wr_n == ew) len++;
      check("wr_width", len, PULSE);
      bad = 0;
      for (int k = s - SETUP; k < s + PULSE + HOLD; k++) begin
        if (k < 0 || k >= q.size()) bad++;
        else begin
          if (q[k].a != 2'(3 - (i % 4)) || q[k].d != ref_char(int'(mem[i]))) bad++;
          if ((k < s || k >= s + PULSE) && q[k].wr_n != 4'hF) bad++;
        end
      end
      check("setup_hold_window", bad, 0);
    end
    if (starts.size() == 16 && dones.size() > 0)
      check("frame_done_pos", dones[0] - starts[15], PULSE + HOLD);
  endtask

  initial begin
    string s = "TINY_TAPEOUT_10!";
    bit found;
    int fd0;
    for (int i = 0; i < 16; i++) mem[i] = s[i];

    repeat (3) @(negedge clk);
    check_reset_outputs();
    i_reset = 1'b0;
    rst_b   = 1'b0;
    q.delete();
    wait_done();
    analyze_frame();

    mem[5] = 8'h7F;
    mem[9] = 8'h0A;
    q.delete();
    pulse_req();
    wait_done();
    analyze_frame();

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++)
        mem[i] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(32, 95))
                                            : 8'($urandom_range(0, 255));
      q.delete();
      pulse_req();
      wait_done();
      analyze_frame();
    end

    fd0 = fd_total;
    pulse_req();
    repeat (30) @(negedge clk);
    repeat (3) begin
      pulse_req();
      repeat (5) @(negedge clk);
    end
    repeat (500) @(negedge clk);
    check("coalesced_frames", fd_total - fd0, 2);

    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(32, 95));
    q.delete();
    pulse_req();
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (a_wr_n == 4'b1101 && a_addr == 2'd1) found = 1;
    end
    check("reached_idx6_strobe", 32'(found), 1);
    i_reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    i_reset = 1'b0;
    q.delete();
    wait_done();
    analyze_frame();

    repeat (20) @(negedge clk);
    check("blink_frames_ran", 32'(b_frames >= 4), 1);
    check("blink_toggle_count", b_toggles, b_frames / 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hpdl1414_scanner.md
# hpdl1414_scanner

- Read-side consumer of the 16-byte display buffer.
- Walks buffer addresses 0..15 once per refresh frame and fetches each character through the buffer's registered read port.
- Writes each character into four HPDL-1414 four-digit displays with the chip's address/data/WR_n write-cycle timing.
- Generates the caret blink strobe the buffer uses to alternate the cursor cell.

## Interface
Parameters:
- SETUP_CYCLES, 2 — cycles address/data are stable before WR_n falls (≥1).
- PULSE_CYCLES, 4 — WR_n low width in cycles (≥1).
- HOLD_CYCLES, 2 — cycles address/data are held after WR_n rises (≥1).
- FRAME_CYCLES, 240000 — frame tick period (20 ms at 12 MHz). Must exceed 16*(2+SETUP+PULSE+HOLD).
- BLINK_FRAMES, 25 — completed frames between caret strobe toggles (≥1).

Ports:
- i_clk  in  1  system clock; the block's only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_refresh_req  in  1  one-cycle request for an immediate frame (e.g. tied to the buffer write enable).
- o_read_enable  out  1  buffer read strobe, one cycle per character.
- o_read_address  out  4  buffer read address.
- i_read_data  in  8  buffer read data; registered, valid the cycle after o_read_enable.
- o_caret_strobe  out  1  blink phase to the buffer: 1 = show character, 0 = show caret.
- o_disp_addr  out  2  HPDL-1414 A1:A0, shared by all chips.
- o_disp_data  out  7  HPDL-1414 D6:D0, shared by all chips.
- o_disp_wr_n  out  4  per-chip active-low write strobes; bit k drives chip k.
- o_frame_done  out  1  one-cycle pulse after the 16th character's HOLD completes.

## Operation
- FSM states: IDLE, READ, LATCH, SETUP, STROBE, HOLD.
- IDLE: waits for the pending flag. When set, clears it, sets idx=0 and goes to READ.
- READ: o_read_enable=1, o_read_address=idx for exactly this cycle → LATCH.
- LATCH: captures i_read_data and maps it to char → SETUP.
  - Data in 0x20..0x5F passes through.
  - All other values (including bit7 set) become 0x20.
- SETUP: o_disp_data=char[6:0]; o_disp_addr=3-idx[1:0]. Digit 3 is leftmost, so idx 0 lands at the left of chip 0.
  - Held for SETUP_CYCLES → STROBE.
- STROBE: o_disp_wr_n[idx[3:2]]=0 for PULSE_CYCLES; all other bits stay 1 → HOLD.
- HOLD: all WR_n=1, address/data unchanged for HOLD_CYCLES. Then:
  - idx<15: idx+1 → READ.
  - idx==15: pulse o_frame_done → IDLE.
- Pending flag:
  - Set by the frame tick (free-running counter wrapping at FRAME_CYCLES-1) or by i_refresh_req.
  - Set/clear coincidence in IDLE: set wins, so at most one further frame follows.
  - A request during a frame never aborts it; requests coalesce into one pending frame.
- Blink: a frame counter increments on each o_frame_done.
  - On reaching BLINK_FRAMES-1 it wraps to 0 and o_caret_strobe toggles.
  - The strobe therefore changes only between frames, so a frame is never half caret, half character.
- Counter widths are derived with $clog2. idx is 4 bits and wraps 15→0 only through IDLE.

## Timing
- Reset values: o_read_enable=0, o_read_address=0, o_caret_strobe=1, o_disp_addr=0, o_disp_data=0, o_disp_wr_n=4'hF, o_frame_done=0; state IDLE, pending=1 (first frame starts right after reset), frame/blink counters 0.
- Cycles per character = 2+SETUP+PULSE+HOLD (10 at defaults); a frame is 160 cycles.
- The first READ comes 1 cycle after IDLE sees pending.
- Address/data change only in SETUP entry, never while any WR_n is low.
- Reset asserted mid-frame: all outputs return to reset values on the next edge.
  - WR_n goes high immediately; an interrupted character is not completed.
- All outputs are registered.

## Structure
- Package hpdl1414_pkg:
  - state encoding
  - CHAR_MIN=0x20, CHAR_MAX=0x5F, CHAR_BLANK=0x20
  - NUM_CHIPS=4, DIGITS_PER_CHIP=4
- Sub-module hpdl1414_frame_timer: frame tick counter plus blink frame counter/toggle. The FSM, idx, and output registers stay in the top module.

## Test plan
- Reset, buffer model preloaded "TINY_TAPEOUT_10!" → 16 writes in order.
  - Chip 0 digits 3,2,1,0 get 0x54,0x49,0x4E,0x59; chip 3 digit 0 gets 0x21.
  - Each WR_n low for exactly 4 cycles, with 2 cycles setup and 2 hold.
- Buffer returns 0x7F at address 5 and 0x0A at address 9 → both written as 0x20 to chip 1 digit 2 and chip 2 digit 2.
- Check read handshake: o_read_enable is a single cycle and data is sampled the following cycle. Buffer model with a 1-cycle registered port → no stale data.
- i_refresh_req pulsed 3 times mid-frame → exactly one extra frame after the current one; o_frame_done pulses twice total.
- Run with BLINK_FRAMES=2, FRAME_CYCLES=400 → o_caret_strobe toggles every 2nd o_frame_done and never changes while state≠IDLE.
- Assert i_reset during STROBE of idx 6 → next cycle o_disp_wr_n=4'hF and all outputs at reset values; new frame starts at idx 0.
